// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller (forwarding, stalls, flushes, memory-wait timeout)
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1D,
    input  logic [4:0]  rs2D,
    input  logic [4:0]  rs1E,
    input  logic [4:0]  rs2E,
    input  logic [4:0]  RdE,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        Select_C,
    output logic        Select_D,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lw_stall;
    logic       mem_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic we_m, input logic [4:0] rd_w,
                                           input logic we_w);
        if (rs != 5'd0 && rs == rd_m && we_m)
            return 2'b10;
        else if (rs != 5'd0 && rs == rd_w && we_w)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && (rs1D == RdE || rs2D == RdE);
    assign mem_stall = MemReqM && !MemReadyM;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        Select_C  = 1'b0;
        Select_D  = 1'b0;
        halted    = 1'b0;
        if (rst_n) begin
            ForwardAE = fwd_sel(rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(rs2E, RdM, RegWriteM, RdW, RegWriteW);
            Select_C  = RegWriteW && (RdW != 5'd0) && (RdW == rs1D);
            Select_D  = RegWriteW && (RdW != 5'd0) && (RdW == rs2D);
            if (state == HALT || mem_stall) begin
                // Freeze the whole pipe; branch/load-use stay pending until memory finishes.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushW = 1'b1;
                halted = (state == HALT);
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall || PCSrcE;
                FlushW = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= 8'd0;
                    if (mem_stall)
                        state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else begin
                        // Completion in the timeout cycle wins because MemReadyM is tested first.
                        if (wait_cnt == 8'(MEM_TIMEOUT - 1))
                            state <= HALT;
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (StallF && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
            if (FlushD && flush_q != 32'hFFFF_FFFF)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with a rule-level reference model
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b1;
    logic        rst_n;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, RdE, RdM, RdW;
    logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        Select_C, Select_D, halted;
    logic [31:0] stall_cycles, flush_count;

    hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Select_C(Select_C), .Select_D(Select_D), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] stall;
        logic [2:0] flush;
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       selc;
        logic       seld;
        logic       halt;
    } ctrl_t;

    typedef struct {
        ctrl_t       ctrl;
        logic [63:0] perf;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference state: length of the current unbroken memory-stall run, halt flag, counters.
    int          run_len = 0;
    bit          halted_m = 0;
    logic [31:0] sc_m = 0;
    logic [31:0] fc_m = 0;

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (rs != 0 && rs == RdM && RegWriteM) return 2'b10;
        if (rs != 0 && rs == RdW && RegWriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic ctrl_t predict();
        ctrl_t c;
        bit lw, ms;
        lw = ResultSrcE0 && RdE != 0 && (rs1D == RdE || rs2D == RdE);
        ms = MemReqM && !MemReadyM;
        if (!rst_n) begin
            c = '{stall: 4'b0000, flush: 3'b111, fae: 2'b00, fbe: 2'b00, selc: 1'b0, seld: 1'b0, halt: 1'b0};
        end else begin
            c.fae  = fwd(rs1E);
            c.fbe  = fwd(rs2E);
            c.selc = RegWriteW && RdW != 0 && RdW == rs1D;
            c.seld = RegWriteW && RdW != 0 && RdW == rs2D;
            c.halt = halted_m;
            if (halted_m || ms) begin
                c.stall = 4'b1111;
                c.flush = 3'b001;
            end else begin
                c.stall = {lw, lw, 2'b00};
                c.flush = {PCSrcE, lw || PCSrcE, 1'b0};
            end
        end
        return c;
    endfunction

    task automatic go();
        exp_t e;
        e.ctrl = predict();
`ifdef HAZARD_PERF_EN
        e.perf = {sc_m, fc_m};
`else
        e.perf = 64'd0;
`endif
        sb.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            run_len  = 0;
            halted_m = 0;
            sc_m     = 0;
            fc_m     = 0;
        end else begin
            if (e.ctrl.stall[3] && sc_m != 32'hFFFF_FFFF) sc_m = sc_m + 1;
            if (e.ctrl.flush[2] && fc_m != 32'hFFFF_FFFF) fc_m = fc_m + 1;
            if (!halted_m) begin
                if (MemReqM && !MemReadyM) begin
                    run_len = run_len + 1;
                    if (run_len == TO + 1) halted_m = 1;
                end else begin
                    run_len = 0;
                end
            end
        end
        #1;
    endtask

    task automatic clear_in();
        rst_n = 1; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    always begin
        exp_t  e;
        ctrl_t act;
        @(negedge clk);
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            act = '{stall: {StallF, StallD, StallE, StallM}, flush: {FlushD, FlushE, FlushW},
                    fae: ForwardAE, fbe: ForwardBE, selc: Select_C, seld: Select_D, halt: halted};
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl t=%0t: got %h expected %h", $time, act, e.ctrl);
            end
            checks++;
            if ({stall_cycles, flush_count} !== e.perf) begin
                errors++;
                $display("FAIL perf t=%0t: got %h expected %h", $time, {stall_cycles, flush_count}, e.perf);
            end
        end
    end

    initial begin
        clear_in();
        rst_n = 0;
        go(); go();
        rst_n = 1;
        go();
        // Three-cycle memory wait, then one load-use stall.
        MemReqM = 1; MemReadyM = 0;
        go(); go(); go();
        MemReadyM = 1; go();
        clear_in();
        ResultSrcE0 = 1; RdE = 7; rs2D = 7; go();
        RdE = 0; go();
        clear_in();
        // Forwarding priority and x0 exclusion.
        rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; rs1D = 5; go();
        RegWriteM = 0; go();
        rs1E = 0; RegWriteM = 1; go();
        clear_in();
        PCSrcE = 1; go();
        // Branch pending across a memory wait.
        MemReqM = 1; go(); go(); go();
        MemReadyM = 1; go();
        clear_in();
        // Timeout into HALT, sticky through ready, cleared by one reset edge.
        MemReqM = 1;
        for (int i = 0; i < TO + 3; i++) go();
        MemReadyM = 1; go(); go();
        rst_n = 0; go();
        clear_in(); go();
        // Completion exactly in the timeout cycle.
        MemReqM = 1;
        for (int i = 0; i < TO; i++) go();
        MemReadyM = 1; go();
        clear_in(); go();

        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            rs1D        = 5'($urandom_range(0, 3));
            rs2D        = 5'($urandom_range(0, 3));
            rs1E        = 5'($urandom_range(0, 3));
            rs2E        = 5'($urandom_range(0, 3));
            RdE         = 5'($urandom_range(0, 3));
            RdM         = 5'($urandom_range(0, 3));
            RdW         = 5'($urandom_range(0, 3));
            ResultSrcE0 = 1'($urandom_range(0, 1));
            PCSrcE      = ($urandom_range(0, 3) == 0);
            RegWriteM   = 1'($urandom_range(0, 1));
            RegWriteW   = 1'($urandom_range(0, 1));
            MemReqM     = (!halted_m && run_len > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            MemReadyM   = ($urandom_range(0, 2) == 0);
            go();
        end

        clear_in();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sequences the F/D/E/M/W pipeline registers and resolves three hazard classes:
- operand forwarding into Execute, plus the Decode-stage write-back bypass (Select_C/Select_D into the decoder);
- load-use stalls and branch/jump flushes;
- multi-cycle data-memory waits, with a timeout that halts the core.

## Interface
Parameters:
- MEM_TIMEOUT, 64: max consecutive not-ready cycles on a memory access before HALT; legal range 2..255.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- rs1D, rs2D  in  5  source registers of instruction in Decode
- rs1E, rs2E, RdE  in  5  sources/destination of instruction in Execute
- ResultSrcE0  in  1  instruction in Execute is a load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- RdM, RdW  in  5  destination registers in Memory / Writeback
- RegWriteM, RegWriteW  in  1  register write enables in Memory / Writeback
- MemReqM  in  1  load/store active in Memory
- MemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  clear the corresponding pipeline register (bubble)
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 regfile, 10 from M, 01 from W
- Select_C, Select_D  out  1  Decode bypass of Result into RD1D / RD2D
- halted  out  1  core halted on memory timeout
- stall_cycles, flush_count  out  32  performance counters (see Configuration)

## Operation
- Forwarding (combinational):
  - ForwardAE = 10 if rs1E!=0, rs1E==RdM and RegWriteM;
  - else 01 if rs1E!=0, rs1E==RdW and RegWriteW;
  - else 00.
  - ForwardBE is identical using rs2E. M has priority over W.
- Decode bypass: Select_C = RegWriteW & RdW!=0 & RdW==rs1D; Select_D is the same with rs2D.
- lwStall = ResultSrcE0 & RdE!=0 & (rs1D==RdE | rs2D==RdE).
- memStall = MemReqM & !MemReadyM.
- FSM states and transitions:
  - RUN → MEM_WAIT when memStall.
  - MEM_WAIT → RUN on MemReadyM.
  - MEM_WAIT → HALT when wait_cnt==MEM_TIMEOUT-1 and !MemReadyM.
  - HALT is exited only by reset.
- wait_cnt (8-bit): cleared in RUN; increments every MEM_WAIT cycle with !MemReadyM.
- Output equations in RUN/MEM_WAIT:
  - If memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. The branch and load-use conditions are held, not acted on.
  - Otherwise: StallF=StallD=lwStall, StallE=StallM=0, FlushD=PCSrcE, FlushE=lwStall|PCSrcE, FlushW=0.
- Outputs in HALT: all four stalls=1, FlushW=1, FlushD=FlushE=0, halted=1.
- Forwarding and bypass outputs are active in every state.

## Timing
- All stall, flush, forward and select outputs are combinational from the inputs and the current state; zero-cycle latency.
- The state register and wait_cnt update on the clk edge.
- Memory handshake:
  - The requester holds MemReqM and the M-stage contents stable while StallM=1.
  - In the cycle where MemReadyM=1, all stalls drop; the pipeline advances on that edge.
- HALT timing: with MemReadyM held low, halted rises on the clock edge ending the MEM_TIMEOUT-th wait cycle. HALT is entered at that same edge.
- MemReadyM rising in the same cycle the timeout is reached: completion wins; the FSM returns to RUN.
- Reset:
  - While rst_n=0: StallF/D/E/M=0, FlushD=FlushE=FlushW=1, ForwardAE/BE=00, Select_C/D=0, halted=0.
  - On the reset edge: state=RUN, wait_cnt=0, counters=0.
  - Reset asserted mid-wait or in HALT takes effect at the next edge regardless of MemReadyM.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments each non-reset cycle with StallF=1.
  - flush_count increments each cycle with FlushD=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- HAZARD_PERF_EN undefined: no counter registers are built; both ports are driven constant 0.

## Test plan
- Forwarding:
  - rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10.
  - Same with RegWriteM=0 → ForwardAE=01.
  - rs1E=0 with all matches → ForwardAE=00.
- Load-use: ResultSrcE0=1, RdE=7, rs2D=7 → StallF=StallD=FlushE=1, FlushD=0 for exactly that cycle. The same stimulus with RdE=0 → all stalls and flushes 0.
- Branch: PCSrcE=1, no other hazard → FlushD=FlushE=1, StallF=0.
- Memory wait:
  - MemReqM=1, MemReadyM=0 for 3 cycles, then 1 → StallF..StallM=1 and FlushW=1 for 3 cycles; all deassert in the ready cycle.
  - With PCSrcE=1 during the wait → FlushD=0 throughout.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 → halted=1 after 4 wait cycles and stays set after MemReadyM=1. rst_n=0 for one edge → halted=0, state RUN.
- HAZARD_PERF_EN defined: 3-cycle memory wait plus 1 load-use stall → stall_cycles=4, flush_count=0. Without the macro → both ports read 0.
